qupls4_agen_seq: RTL and testbench
==================================

# qupls4_agen_seq

Parametrised, sequencing address generator for the Qupls4 load/store unit. Accepts one memory op from a reservation-station issue port and emits a stream of effective addresses through a valid/ready port toward the TLB/dcache, one per cycle. Handles scalar, AMO and strided-vector ops, and splits any access that crosses a cache line into two line-aligned beats. The lane counter and the stride are an accumulator, so there is no multiplier in the path.

## Interface
- AWID, 64, address width in bits.
- LINE_BITS, 6, log2 of the cache-line size in bytes.
- MAX_LANES, 64, maximum vector lane count; LANE_W = clog2(MAX_LANES)+1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low; all state is cleared while low.
- flush  in  1  synchronous abort (branch miss or TLB shootdown); takes priority over everything except rst.
- req_v  in  1  request valid.
- req_rdy  out  1  ready for a request; high only in IDLE.
- req_mode  in  2  request mode: 0 scalar, 1 amo, 2 strided vector, 3 reserved (treated as scalar).
- req_base  in  AWID  base address, argA.
- req_ndx  in  AWID  index or stride, argB.
- req_sc  in  3  shift amount applied to req_ndx.
- req_imm  in  AWID  displacement, argI.
- req_size  in  3  log2 of access bytes (0 to 6).
- req_nlanes  in  LANE_W  lane count; 0 is treated as 1.
- out_v  out  1  output address valid.
- out_rdy  in  1  consumer ready.
- out_addr  out  AWID  effective address.
- out_lane  out  LANE_W  lane number of this beat.
- out_split  out  1  marks the second, line-aligned beat of a crossing access.
- out_last  out  1  marks the final beat of the op.
- out_err  out  1  misaligned AMO; set on that op's single beat.

## Operation
- S = req_ndx << req_sc, truncated to AWID. All address sums are modulo 2^AWID; wrap-around is silent.
- The request is captured when req_v && req_rdy. Latched fields are held for the whole op.
- **IDLE:**
  - req_rdy = 1 and out_v = 0.
  - On capture: acc = req_base + req_imm and lane = 0.
  - Scalar ops also add S into acc.
  - Go to GEN.
- **GEN:**
  - Present out_addr = acc and out_lane = lane.
  - Crossing test: cross = (acc[LINE_BITS-1:0] + (1<<size)) > (1<<LINE_BITS).
  - On handshake (out_v && out_rdy), with cross = 1 and not amo: go to SPLIT.
  - On handshake, otherwise, when this is the last lane: go to IDLE.
  - On handshake, otherwise: acc += S, lane += 1, stay in GEN.
- **SPLIT:**
  - Present out_addr = {acc[AWID-1:LINE_BITS] + 1, LINE_BITS zeros} with out_split = 1.
  - On handshake: advance the lane exactly as in GEN, or go to IDLE if this was the last lane.
- **Last-lane rule:**
  - A lane is last when lane == max(nlanes,1) - 1.
  - Scalar and AMO ops always have exactly one lane.
  - out_last = last lane && !cross in GEN, or last lane in SPLIT.
- **AMO:**
  - Address = req_base only; req_ndx and req_imm are ignored.
  - Never split.
  - out_err = 1 if acc[size-1:0] != 0. The beat is still emitted with out_last = 1.
- **Mode 3:** behaves exactly as scalar.
- **Output holding:** out_* is registered. With out_v = 1 and out_rdy = 0, all out_* hold stable; there are no combinational paths from out_rdy to out_*.
- **flush:** forces IDLE and clears out_v on the next edge. A beat presented in the same cycle as flush counts as delivered only if out_rdy was high.
- **rst low:** at any time, mid-op included, the block returns to IDLE asynchronously.

## Timing
- Reset values: out_v = 0, out_addr = 0, out_lane = 0, out_split = 0, out_last = 0, out_err = 0.
- State resets to IDLE, so req_rdy = 1 as soon as rst deasserts.
- Latency: first out_v is 1 cycle after capture.
- Throughput, no backpressure: one beat per cycle. A vector op of N lanes with k crossings takes N+k cycles.
- req_rdy returns high the cycle after the last handshake. Back-to-back ops therefore have a 1-cycle bubble.
- Backpressure: stalling out_rdy for any number of cycles adds exactly that many cycles and loses no beat.
- Simultaneous flush and req_v in IDLE: flush wins and the request is not captured.

## Test plan
- **Scalar, no cross:** base=0x1000, ndx=3, sc=3, imm=0x10, size=3 -> one beat, addr 0x1028, last=1, split=0, 1 cycle after capture.
- **Scalar cross:** base=0x103C, ndx=0, imm=0, size=3 -> beats 0x103C (last=0), then 0x1040 (split=1, last=1).
- **Strided vector:** base=0x2000, ndx=0x10, sc=0, imm=4, nlanes=4, size=2 -> 0x2004, 0x2014, 0x2024, 0x2034 with lanes 0-3, last only on lane 3.
- **Vector with crossing plus backpressure:** stride 0x1C, base 0x3020, size=3, nlanes=3, out_rdy toggled every cycle.
  - Lane addrs 0x3020, 0x303C, 0x3058; only lane 1 crosses, producing extra beat 0x3040 (split=1).
  - Expect the sequence 0x3020, 0x303C, 0x3040, 0x3058, with no drops or duplicates and outputs stable while stalled.
- **AMO misaligned:** mode=1, base=0x4004, size=3, imm=0x100 -> single beat 0x4004, err=1, last=1, no split.
- **Flush and reset:**
  - flush asserted during lane 2 of an 8-lane op -> out_v=0 next cycle and req_rdy=1; a new scalar op then completes normally.
  - rst pulsed low mid-op -> all outputs read their reset values immediately.

Source files
------------

// File: rtl/qupls4_agen_seq.sv
// Sequencing address generator for the Qupls4 load/store unit.
// Emits one registered effective address per cycle; splits line-crossing accesses into two beats.
module qupls4_agen_seq #(
    parameter int AWID      = 64,
    parameter int LINE_BITS = 6,
    parameter int MAX_LANES = 64,
    parameter int LANE_W    = $clog2(MAX_LANES) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_v,
    output logic              req_rdy,
    input  logic [1:0]        req_mode,
    input  logic [AWID-1:0]   req_base,
    input  logic [AWID-1:0]   req_ndx,
    input  logic [2:0]        req_sc,
    input  logic [AWID-1:0]   req_imm,
    input  logic [2:0]        req_size,
    input  logic [LANE_W-1:0] req_nlanes,
    output logic              out_v,
    input  logic              out_rdy,
    output logic [AWID-1:0]   out_addr,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_split,
    output logic              out_last,
    output logic              out_err
);

    localparam int CW = LINE_BITS + 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_SPLIT = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [AWID-1:0]     acc_reg, acc_next;
    logic [AWID-1:0]     stride_reg, stride_next;
    logic [LANE_W-1:0]   lane_reg, lane_next;
    logic [LANE_W-1:0]   last_lane_reg, last_lane_next;
    logic [2:0]          size_reg, size_next;
    logic                amo_reg, amo_next;

    logic                out_v_reg, out_v_next;
    logic [AWID-1:0]     out_addr_reg, out_addr_next;
    logic [LANE_W-1:0]   out_lane_reg, out_lane_next;
    logic                out_split_reg, out_split_next;
    logic                out_last_reg, out_last_next;
    logic                out_err_reg, out_err_next;

    logic                handshake;
    logic                cur_cross;
    logic                cur_last;
    logic                nxt_cross;
    logic                nxt_last;

    logic [AWID-1:0]     req_stride;
    logic                req_amo;
    logic                req_vec;
    logic [AWID-1:0]     req_acc;
    logic [LANE_W-1:0]   req_last_lane;

    // True when an access of 2^sz bytes at a spills past the end of its cache line.
    function automatic logic crosses(input logic [AWID-1:0] a, input logic [2:0] sz);
        logic [CW-1:0] off;
        off = CW'(a[LINE_BITS-1:0]) + (CW'(1) << sz);
        return off > (CW'(1) << LINE_BITS);
    endfunction

    function automatic logic misaligned(input logic [AWID-1:0] a, input logic [2:0] sz);
        return (a & ((AWID'(1) << sz) - AWID'(1))) != '0;
    endfunction

    function automatic logic [AWID-1:0] next_line(input logic [AWID-1:0] a);
        return {a[AWID-1:LINE_BITS], {LINE_BITS{1'b0}}} + (AWID'(1) << LINE_BITS);
    endfunction

    assign req_rdy   = (state_reg == ST_IDLE);
    assign handshake = out_v_reg && out_rdy;

    // Request decode; mode 3 falls through to the scalar path.
    always_comb begin
        req_stride    = req_ndx << req_sc;
        req_amo       = (req_mode == 2'd1);
        req_vec       = (req_mode == 2'd2);
        req_acc       = req_base + req_imm + req_stride;
        req_last_lane = '0;
        if (req_amo) begin
            req_acc = req_base;
        end else if (req_vec) begin
            req_acc = req_base + req_imm;
            if (req_nlanes != '0) begin
                req_last_lane = req_nlanes - LANE_W'(1);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        stride_next    = stride_reg;
        lane_next      = lane_reg;
        last_lane_next = last_lane_reg;
        size_next      = size_reg;
        amo_next       = amo_reg;

        cur_cross = crosses(acc_reg, size_reg) && !amo_reg;
        cur_last  = (lane_reg == last_lane_reg);

        case (state_reg)
            ST_IDLE: begin
                if (req_v) begin
                    acc_next       = req_acc;
                    stride_next    = req_stride;
                    lane_next      = '0;
                    last_lane_next = req_last_lane;
                    size_next      = req_size;
                    amo_next       = req_amo;
                    state_next     = ST_GEN;
                end
            end
            ST_GEN: begin
                if (handshake) begin
                    if (cur_cross) begin
                        state_next = ST_SPLIT;
                    end else if (cur_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        acc_next  = acc_reg + stride_reg;
                        lane_next = lane_reg + LANE_W'(1);
                    end
                end
            end
            ST_SPLIT: begin
                if (handshake) begin
                    if (cur_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        acc_next   = acc_reg + stride_reg;
                        lane_next  = lane_reg + LANE_W'(1);
                        state_next = ST_GEN;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (flush) begin
            state_next = ST_IDLE;
        end

        // Output registers are loaded with the beat the next state will present,
        // so a stalled beat simply recomputes to the same value.
        out_v_next     = 1'b0;
        out_addr_next  = out_addr_reg;
        out_lane_next  = out_lane_reg;
        out_split_next = out_split_reg;
        out_last_next  = out_last_reg;
        out_err_next   = out_err_reg;

        nxt_cross = crosses(acc_next, size_next) && !amo_next;
        nxt_last  = (lane_next == last_lane_next);

        if (state_next == ST_SPLIT) begin
            out_v_next     = 1'b1;
            out_addr_next  = next_line(acc_next);
            out_lane_next  = lane_next;
            out_split_next = 1'b1;
            out_last_next  = nxt_last;
            out_err_next   = 1'b0;
        end else if (state_next == ST_GEN) begin
            out_v_next     = 1'b1;
            out_addr_next  = acc_next;
            out_lane_next  = lane_next;
            out_split_next = 1'b0;
            out_last_next  = nxt_last && !nxt_cross;
            out_err_next   = amo_next && misaligned(acc_next, size_next);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            stride_reg    <= '0;
            lane_reg      <= '0;
            last_lane_reg <= '0;
            size_reg      <= '0;
            amo_reg       <= 1'b0;
            out_v_reg     <= 1'b0;
            out_addr_reg  <= '0;
            out_lane_reg  <= '0;
            out_split_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            stride_reg    <= stride_next;
            lane_reg      <= lane_next;
            last_lane_reg <= last_lane_next;
            size_reg      <= size_next;
            amo_reg       <= amo_next;
            out_v_reg     <= out_v_next;
            out_addr_reg  <= out_addr_next;
            out_lane_reg  <= out_lane_next;
            out_split_reg <= out_split_next;
            out_last_reg  <= out_last_next;
            out_err_reg   <= out_err_next;
        end
    end

    assign out_v     = out_v_reg;
    assign out_addr  = out_addr_reg;
    assign out_lane  = out_lane_reg;
    assign out_split = out_split_reg;
    assign out_last  = out_last_reg;
    assign out_err   = out_err_reg;

endmodule

// File: tb/tb_qupls4_agen_seq.sv
// Randomized self-checking bench for qupls4_agen_seq against a per-lane address model.
module tb_qupls4_agen_seq;

    localparam int AWID      = 64;
    localparam int LINE_BITS = 6;
    localparam int MAX_LANES = 64;
    localparam int LANE_W    = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              req_v = 1'b0;
    logic              req_rdy;
    logic [1:0]        req_mode = '0;
    logic [AWID-1:0]   req_base = '0;
    logic [AWID-1:0]   req_ndx = '0;
    logic [2:0]        req_sc = '0;
    logic [AWID-1:0]   req_imm = '0;
    logic [2:0]        req_size = '0;
    logic [LANE_W-1:0] req_nlanes = '0;
    logic              out_v;
    logic              out_rdy = 1'b0;
    logic [AWID-1:0]   out_addr;
    logic [LANE_W-1:0] out_lane;
    logic              out_split;
    logic              out_last;
    logic              out_err;

    typedef struct {
        logic [63:0] addr;
        logic [6:0]  lane;
        logic        split;
        logic        last;
        logic        err;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    qupls4_agen_seq #(
        .AWID(AWID), .LINE_BITS(LINE_BITS), .MAX_LANES(MAX_LANES), .LANE_W(LANE_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_v(req_v), .req_rdy(req_rdy), .req_mode(req_mode),
        .req_base(req_base), .req_ndx(req_ndx), .req_sc(req_sc),
        .req_imm(req_imm), .req_size(req_size), .req_nlanes(req_nlanes),
        .out_v(out_v), .out_rdy(out_rdy), .out_addr(out_addr), .out_lane(out_lane),
        .out_split(out_split), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each lane sits at base+imm+i*S; a crossing lane adds the start of the next line.
    task automatic build_model(input logic [1:0] mode, input logic [63:0] base, input logic [63:0] ndx,
                               input logic [2:0] sc, input logic [63:0] imm, input logic [2:0] size,
                               input logic [6:0] nl);
        logic [63:0] s, a, line, bytes;
        logic        amo, vec, cr, lst;
        int          n;
        beat_t       b;
        exp_q.delete();
        line  = 64'd64;
        bytes = 64'd1 << size;
        s     = ndx << sc;
        amo   = (mode == 2'd1);
        vec   = (mode == 2'd2);
        n     = vec ? ((nl == 0) ? 1 : int'(nl)) : 1;
        for (int i = 0; i < n; i++) begin
            if (amo)      a = base;
            else if (vec) a = base + imm + 64'(i) * s;
            else          a = base + imm + s;
            cr  = !amo && ((a % line) + bytes > line);
            lst = (i == n - 1);
            b.addr  = a;
            b.lane  = 7'(i);
            b.split = 1'b0;
            b.last  = lst && !cr;
            b.err   = amo && ((a % bytes) != 0);
            exp_q.push_back(b);
            if (cr) begin
                b.addr  = (a / line + 1) * line;
                b.split = 1'b1;
                b.last  = lst;
                b.err   = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic begin_op(input logic [1:0] mode, input logic [63:0] base, input logic [63:0] ndx,
                            input logic [2:0] sc, input logic [63:0] imm, input logic [2:0] size,
                            input logic [6:0] nl);
        build_model(mode, base, ndx, sc, imm, size, nl);
        chk("req_rdy_before", 64'(req_rdy), 64'd1);
        req_mode = mode; req_base = base; req_ndx = ndx; req_sc = sc;
        req_imm = imm; req_size = size; req_nlanes = nl;
        req_v = 1'b1;
        @(negedge clk);
        req_v = 1'b0;
    endtask

    // rdy_mode: percent chance of out_rdy each cycle, or -1 to toggle starting stalled.
    task automatic collect(input int rdy_mode, input string name);
        int    cyc = 0;
        int    nb;
        logic  tog = 1'b0;
        beat_t b;
        nb = exp_q.size();
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (rdy_mode < 0) begin
                out_rdy = tog;
                tog = ~tog;
            end else begin
                out_rdy = ($urandom_range(0, 99) < rdy_mode);
            end
            b = exp_q[0];
            chk({name, "_v"}, 64'(out_v), 64'd1);
            chk({name, "_addr"}, out_addr, b.addr);
            chk({name, "_flags"}, 64'({out_lane, out_split, out_last, out_err}),
                64'({b.lane, b.split, b.last, b.err}));
            if (out_v && out_rdy) b = exp_q.pop_front();
            @(negedge clk);
            cyc++;
        end
        chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
        if (rdy_mode == 100) chk({name, "_cycles"}, 64'(cyc), 64'(nb));
        out_rdy = 1'b0;
        chk({name, "_done_v"}, 64'(out_v), 64'd0);
        chk({name, "_done_rdy"}, 64'(req_rdy), 64'd1);
        $display("[TB] op %s: %0d beats in %0d cycles", name, nb, cyc);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_v"}, 64'(out_v), 64'd0);
        chk({name, "_addr"}, out_addr, 64'd0);
        chk({name, "_flags"}, 64'({out_lane, out_split, out_last, out_err}), 64'd0);
        chk({name, "_rdy"}, 64'(req_rdy), 64'd1);
    endtask

    initial begin
        int cyc;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        begin_op(2'd0, 64'h1000, 64'd3, 3'd3, 64'h10, 3'd3, 7'd1);
        collect(100, "scalar");
        begin_op(2'd0, 64'h103C, 64'd0, 3'd0, 64'h0, 3'd3, 7'd1);
        collect(100, "scalar_cross");
        begin_op(2'd2, 64'h2000, 64'h10, 3'd0, 64'h4, 3'd2, 7'd4);
        collect(100, "vector");
        begin_op(2'd2, 64'h3020, 64'h1C, 3'd0, 64'h0, 3'd3, 7'd3);
        collect(-1, "vec_cross_bp");
        begin_op(2'd1, 64'h4004, 64'h0, 3'd0, 64'h100, 3'd3, 7'd1);
        collect(100, "amo_misaligned");
        begin_op(2'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 3'd0, 64'd0, 3'd3, 7'd5);
        collect(100, "mode3_wrap");
        begin_op(2'd2, 64'h7000, 64'h8, 3'd0, 64'h0, 3'd0, 7'd0);
        collect(100, "vec_zero_lanes");

        // Flush mid-op while lane 2 is being presented.
        begin_op(2'd2, 64'h5000, 64'h8, 3'd0, 64'h0, 3'd3, 7'd8);
        out_rdy = 1'b1;
        cyc = 0;
        while (!(out_v && out_lane == 7'd2) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("flush_lane", 64'(out_lane), 64'd2);
        chk("flush_addr", out_addr, 64'h5010);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_rdy = 1'b0;
        chk("flush_v", 64'(out_v), 64'd0);
        chk("flush_rdy", 64'(req_rdy), 64'd1);
        exp_q.delete();

        // Flush beats a simultaneous request in IDLE.
        req_mode = 2'd0; req_base = 64'h9000; req_ndx = '0; req_sc = '0;
        req_imm = '0; req_size = 3'd0; req_nlanes = 7'd1;
        req_v = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        req_v = 1'b0;
        flush = 1'b0;
        chk("flushreq_v", 64'(out_v), 64'd0);
        chk("flushreq_rdy", 64'(req_rdy), 64'd1);
        begin_op(2'd0, 64'h8000, 64'h2, 3'd1, 64'h20, 3'd2, 7'd1);
        collect(100, "after_flush");

        // Asynchronous reset mid-op.
        begin_op(2'd2, 64'h6000, 64'h40, 3'd0, 64'h0, 3'd3, 7'd8);
        out_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_lane", 64'(out_lane), 64'd2);
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        out_rdy = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_v", 64'(out_v), 64'd0);

        for (int k = 0; k < 60; k++) begin
            logic [63:0] base;
            base = {$urandom, $urandom};
            if (k % 2 == 0) base = 64'($urandom_range(0, 4095));
            begin_op(2'($urandom_range(0, 3)), base, 64'($urandom_range(0, 255)),
                     3'($urandom_range(0, 7)), 64'($urandom_range(0, 255)),
                     3'($urandom_range(0, 6)), 7'($urandom_range(0, 10)));
            collect(int'($urandom_range(30, 100)), $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
